// File: rtl/ui_result_sequencer.sv
// rtl/ui_result_sequencer.sv - result symbol draw/hold/erase sequencer and VGA pixel mux
//
// Purpose:
//   Sequences one of two result-symbol drawers (tick / cross) through a draw
//   pass, a visible hold period and a clear-mode erase pass, and forwards the
//   selected drawer's pixel stream to the VGA adapter with one cycle latency.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   result_valid, result_correct     new result pulse and its polarity (1 = tick)
//   busy, finished, error            sequence status towards game logic
//   drw_reset_n, drw_clear           shared drawer control (hold / black colour)
//   c_enable, w_enable               per-drawer start pulses
//   c_* / w_*                        tick / cross drawer pixel outputs and done
//   vga_x, vga_y, vga_color, vga_plot registered pixel stream to VGA adapter

module ui_result_sequencer #(
   parameter int unsigned HOLD_CYCLES    = 25000000,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       result_valid,
   input  logic       result_correct,
   output logic       busy,
   output logic       finished,
   output logic       error,
   output logic       drw_reset_n,
   output logic       drw_clear,
   output logic       c_enable,
   output logic       w_enable,
   input  logic [7:0] c_x,
   input  logic [6:0] c_y,
   input  logic [2:0] c_color,
   input  logic       c_writeEn,
   input  logic       c_done,
   input  logic [7:0] w_x,
   input  logic [6:0] w_y,
   input  logic [2:0] w_color,
   input  logic       w_writeEn,
   input  logic       w_done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_color,
   output logic       vga_plot
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ARM,
      S_START,
      S_DRAW,
      S_HOLD,
      S_ERASE_ARM,
      S_ERASE_START,
      S_ERASE,
      S_ABORT,
      S_FINISH
   } state_t;

   // Terminal timer values; a zero parameter still spends one cycle in the phase.
   localparam logic [25:0] HOLD_LAST    = (HOLD_CYCLES == 0)    ? 26'd0 : 26'(HOLD_CYCLES - 1);
   localparam logic [25:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 26'd0 : 26'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic [25:0] r_timer;
   logic        r_sel;        // 1 = cross drawer, 0 = tick drawer
   logic        r_error;
   logic [7:0]  r_vga_x;
   logic [6:0]  r_vga_y;
   logic [2:0]  r_vga_color;
   logic        r_vga_plot;

   logic        w_accept;
   logic        w_sel_done;
   logic        w_sel_we;
   logic [7:0]  w_sel_x;
   logic [6:0]  w_sel_y;
   logic [2:0]  w_sel_color;
   logic        w_pixel_phase;

   assign w_accept      = (r_state == S_IDLE) && result_valid;
   assign w_sel_done    = r_sel ? w_done    : c_done;
   assign w_sel_we      = r_sel ? w_writeEn : c_writeEn;
   assign w_sel_x       = r_sel ? w_x       : c_x;
   assign w_sel_y       = r_sel ? w_y       : c_y;
   assign w_sel_color   = r_sel ? w_color   : c_color;
   assign w_pixel_phase = (r_state == S_DRAW) || (r_state == S_ERASE);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and Moore outputs
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b1;
      finished     = 1'b0;
      drw_reset_n  = 1'b0;
      drw_clear    = 1'b0;
      c_enable     = 1'b0;
      w_enable     = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (result_valid) w_state_next = S_ARM;
         end
         S_ARM: begin
            drw_reset_n  = 1'b1;
            w_state_next = S_START;
         end
         S_START: begin
            drw_reset_n  = 1'b1;
            c_enable     = ~r_sel;
            w_enable     = r_sel;
            w_state_next = S_DRAW;
         end
         S_DRAW: begin
            drw_reset_n = 1'b1;
            // done has priority over a timeout in the same cycle
            if (w_sel_done)                    w_state_next = S_HOLD;
            else if (r_timer >= TIMEOUT_LAST)  w_state_next = S_ABORT;
         end
         S_HOLD: begin
            if (r_timer >= HOLD_LAST) w_state_next = S_ERASE_ARM;
         end
         S_ERASE_ARM: begin
            drw_reset_n  = 1'b1;
            drw_clear    = 1'b1;
            w_state_next = S_ERASE_START;
         end
         S_ERASE_START: begin
            drw_reset_n  = 1'b1;
            drw_clear    = 1'b1;
            c_enable     = ~r_sel;
            w_enable     = r_sel;
            w_state_next = S_ERASE;
         end
         S_ERASE: begin
            drw_reset_n = 1'b1;
            drw_clear   = 1'b1;
            if (w_sel_done)                    w_state_next = S_FINISH;
            else if (r_timer >= TIMEOUT_LAST)  w_state_next = S_ABORT;
         end
         S_ABORT: begin
            w_state_next = S_FINISH;
         end
         S_FINISH: begin
            finished     = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Shared phase timer, selection, sticky error and registered pixel mux
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timer     <= '0;
         r_sel       <= 1'b0;
         r_error     <= 1'b0;
         r_vga_x     <= '0;
         r_vga_y     <= '0;
         r_vga_color <= '0;
         r_vga_plot  <= 1'b0;
      end else begin
         // Restart on every state change, otherwise count up and saturate
         if (w_state_next != r_state) begin
            r_timer <= '0;
         end else if (r_timer != '1) begin
            r_timer <= r_timer + 26'd1;
         end

         if (w_accept) begin
            r_sel   <= ~result_correct;
            r_error <= 1'b0;
         end else if (r_state == S_ABORT) begin
            r_error <= 1'b1;
         end

         // Coordinates only track the drawer while it is drawing or erasing
         if (w_pixel_phase) begin
            r_vga_x     <= w_sel_x;
            r_vga_y     <= w_sel_y;
            r_vga_color <= w_sel_color;
         end
         r_vga_plot <= w_pixel_phase && w_sel_we;
      end
   end

   assign error     = r_error;
   assign vga_x     = r_vga_x;
   assign vga_y     = r_vga_y;
   assign vga_color = r_vga_color;
   assign vga_plot  = r_vga_plot;

endmodule

// File: tb/tb_ui_result_sequencer.sv
// tb/tb_ui_result_sequencer.sv - self-checking bench for ui_result_sequencer
module tb_ui_result_sequencer;

   localparam int HOLD  = 8;
   localparam int TMO   = 100;
   localparam int NEVER = 255;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, result_valid, result_correct;
   logic       busy, finished, error, drw_reset_n, drw_clear, c_enable, w_enable;
   logic [7:0] c_x, w_x, vga_x;
   logic [6:0] c_y, w_y, vga_y;
   logic [2:0] c_color, w_color, vga_color;
   logic       c_writeEn, w_writeEn, c_done, w_done, vga_plot;

   ui_result_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .result_valid(result_valid), .result_correct(result_correct),
      .busy(busy), .finished(finished), .error(error),
      .drw_reset_n(drw_reset_n), .drw_clear(drw_clear),
      .c_enable(c_enable), .w_enable(w_enable),
      .c_x(c_x), .c_y(c_y), .c_color(c_color), .c_writeEn(c_writeEn), .c_done(c_done),
      .w_x(w_x), .w_y(w_y), .w_color(w_color), .w_writeEn(w_writeEn), .w_done(w_done),
      .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot)
   );

   typedef struct {
      bit correct;
      int n_draw;
      int n_erase;
      int extra_at;
      int exp_fin;
      int exp_en;
      int exp_plots;
      int exp_low;
      int exp_clr;
      bit exp_err;
   } vec_t;

   vec_t vecs[6];

   int n_chk = 0, n_fail = 0, cyc = 0;

   // Drawer models and scoreboard state
   bit          act[2];
   int          left[2];
   int          nen[2];
   bit          en_prev[2];
   bit          rst_prev;
   bit          junk;
   int          sel_d;
   int          len_draw, len_erase;
   bit          exp_plot, we_last;
   logic [17:0] exp_px, px_last;
   int          nfin, fin_cyc, nplot, nlow, nclr, p_cyc;
   logic        err_fin, err_p1;
   logic        clr_at[2];

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   // One clock cycle: drive drawer models after the edge, sample at negedge
   task automatic step(input bit rv, input bit rc);
      logic [17:0] px[2];
      bit          we[2];
      bit          dn[2];
      @(posedge clk);
      #1;
      result_valid = rv;
      result_correct = rc;
      exp_plot = we_last;
      exp_px   = px_last;
      for (int d = 0; d < 2; d++) begin
         px[d] = 18'($urandom);
         we[d] = 1'b0;
         dn[d] = 1'b0;
         if (!rst_prev) act[d] = 1'b0;
         if (en_prev[d]) begin
            act[d]  = 1'b1;
            left[d] = (nen[d] <= 1) ? len_draw : len_erase;
         end
         if (act[d]) begin
            if (left[d] == NEVER) begin
               we[d] = 1'b0;
            end else if (left[d] > 0) begin
               we[d] = 1'b1;
               left[d]--;
            end else begin
               dn[d]  = 1'b1;
               act[d] = 1'b0;
            end
         end else if (junk && d != sel_d) begin
            we[d] = 1'($urandom_range(0, 1));
            dn[d] = ($urandom_range(0, 3) == 0);
         end
      end
      c_x = px[0][17:10]; c_y = px[0][9:3]; c_color = px[0][2:0];
      c_writeEn = we[0];  c_done = dn[0];
      w_x = px[1][17:10]; w_y = px[1][9:3]; w_color = px[1][2:0];
      w_writeEn = we[1];  w_done = dn[1];
      we_last = we[sel_d];
      px_last = px[sel_d];

      @(negedge clk);
      cyc++;
      chk("vga_plot", 32'(vga_plot), 32'(exp_plot));
      if (vga_plot && exp_plot) chk("vga_pixel", 32'({vga_x, vga_y, vga_color}), 32'(exp_px));
      if (vga_plot) nplot++;
      en_prev[0] = c_enable;
      en_prev[1] = w_enable;
      for (int d = 0; d < 2; d++) begin
         if (en_prev[d]) begin
            nen[d]++;
            if (d == sel_d && nen[d] <= 2) clr_at[nen[d]-1] = drw_clear;
         end
      end
      rst_prev = drw_reset_n;
      if (finished) begin
         nfin++;
         fin_cyc = cyc;
         err_fin = error;
      end
      if (busy && !drw_reset_n) nlow++;
      if (drw_clear) nclr++;
      if (cyc == p_cyc + 1) err_p1 = error;
   endtask

   task automatic begin_seq(input vec_t v);
      nen[0] = 0; nen[1] = 0;
      nfin = 0; nplot = 0; nlow = 0; nclr = 0; fin_cyc = -1;
      clr_at[0] = 1'b1; clr_at[1] = 1'b0;
      err_fin = 1'bx; err_p1 = 1'bx;
      sel_d = v.correct ? 0 : 1;
      len_draw = v.n_draw;
      len_erase = v.n_erase;
      junk = 1'b1;
      p_cyc = cyc + 1;
      step(1'b1, v.correct);
   endtask

   task automatic run_seq(input vec_t v);
      begin_seq(v);
      for (int k = 1; k <= v.exp_fin + 4; k++) begin
         if (k == v.extra_at) step(1'b1, !v.correct);
         else                 step(1'b0, 1'($urandom_range(0, 1)));
      end
      chk("finished_count", nfin, 1);
      chk("finish_offset", fin_cyc - p_cyc, v.exp_fin);
      chk("sel_enables", nen[sel_d], v.exp_en);
      chk("other_enables", nen[1-sel_d], 0);
      chk("plot_count", nplot, v.exp_plots);
      chk("low_busy_cycles", nlow, v.exp_low);
      chk("clear_cycles", nclr, v.exp_clr);
      chk("error_at_finish", 32'(err_fin), 32'(v.exp_err));
      chk("error_cleared_on_accept", 32'(err_p1), 32'd0);
      chk("clear_on_draw_enable", 32'(clr_at[0]), 32'd0);
      if (v.exp_en == 2) chk("clear_on_erase_enable", 32'(clr_at[1]), 32'd1);
      chk("busy_after", 32'(busy), 32'd0);
      chk("drw_reset_n_after", 32'(drw_reset_n), 32'd0);
      junk = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      //             corr  n      m  extra fin  en plots low clr err
      vecs[0] = '{1'b1, 5,     5, 0,    25,  2, 10,   9,  8,  1'b0};
      vecs[1] = '{1'b0, 5,     5, 0,    25,  2, 10,   9,  8,  1'b0};
      vecs[2] = '{1'b1, 0,     3, 0,    18,  2, 3,    9,  6,  1'b0};
      vecs[3] = '{1'b0, NEVER, 0, 0,    104, 1, 0,    2,  0,  1'b1};
      vecs[4] = '{1'b1, 4,     2, 11,   21,  2, 6,    9,  5,  1'b0};
      vecs[5] = '{1'b0, 12,    7, 2,    34,  2, 19,   9,  10, 1'b0};

      reset_n = 1'b0; result_valid = 1'b0; result_correct = 1'b0;
      c_x = '0; c_y = '0; c_color = '0; c_writeEn = 1'b0; c_done = 1'b0;
      w_x = '0; w_y = '0; w_color = '0; w_writeEn = 1'b0; w_done = 1'b0;
      act[0] = 0; act[1] = 0; en_prev[0] = 0; en_prev[1] = 0; rst_prev = 0;
      junk = 0; sel_d = 0; len_draw = 0; len_erase = 0; we_last = 0; px_last = '0;
      p_cyc = -10;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      chk("reset_vga_x", 32'(vga_x), 32'd0);
      chk("reset_error", 32'(error), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_drw_reset_n", 32'(drw_reset_n), 32'd0);
         chk("idle_finished", 32'(finished), 32'd0);
      end

      for (int i = 0; i < 6; i++) run_seq(vecs[i]);

      // Randomized sequences against the arithmetic timeline model
      for (int i = 0; i < 8; i++) begin
         v.correct  = 1'($urandom_range(0, 1));
         v.n_draw   = int'($urandom_range(0, 15));
         v.n_erase  = int'($urandom_range(0, 15));
         v.exp_fin  = 7 + HOLD + v.n_draw + v.n_erase;
         v.extra_at = int'($urandom_range(1, v.exp_fin - 1));
         v.exp_en   = 2;
         v.exp_plots = v.n_draw + v.n_erase;
         v.exp_low  = HOLD + 1;
         v.exp_clr  = v.n_erase + 3;
         v.exp_err  = 1'b0;
         run_seq(v);
      end

      // Asynchronous reset while the drawer is mid-draw
      v = vecs[0];
      v.n_draw = 10;
      begin_seq(v);
      for (int k = 1; k <= 6; k++) step(1'b0, 1'b1);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_drw_reset_n", 32'(drw_reset_n), 32'd0);
      chk("async_c_enable", 32'(c_enable), 32'd0);
      chk("async_vga_plot", 32'(vga_plot), 32'd0);
      chk("async_vga_x", 32'(vga_x), 32'd0);
      chk("async_finished", 32'(finished), 32'd0);
      act[0] = 0; act[1] = 0; en_prev[0] = 0; en_prev[1] = 0;
      we_last = 1'b0; junk = 1'b0; result_valid = 1'b0;
      c_writeEn = 1'b0; w_writeEn = 1'b0; c_done = 1'b0; w_done = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rst_prev = 1'b0;
      run_seq(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ui_result_sequencer.md
Name: ui_result_sequencer

Overview:
Upstream sequencer and pixel mux for the two result-symbol drawers (correct tick, wrong cross).
- On a result pulse from game logic, arms the selected drawer, waits for its done, holds the symbol on screen, then re-runs the drawer in clear mode to erase it.
- Forwards the active drawer's pixel stream to the VGA adapter and reports completion to game logic.

Parameters:
HOLD_CYCLES, 25000000, clk cycles the symbol stays visible between draw-done and erase start (0.5 s at 50 MHz).
TIMEOUT_CYCLES, 50000000, max cycles to wait for drawer done in either draw phase before aborting.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  asynchronous active-low reset
result_valid  in  1  one-cycle pulse: new result to display
result_correct  in  1  sampled with result_valid: 1 = tick, 0 = cross
busy  out  1  high in every state except IDLE
finished  out  1  one-cycle pulse when sequence ends (normal or abort)
error  out  1  sticky: last sequence aborted on timeout; cleared on next accepted result
drw_reset_n  out  1  to both drawers' reset input; low = drawer held disabled
drw_clear  out  1  to both drawers' clear input; 1 = draw in black
c_enable  out  1  enable pulse to tick drawer
w_enable  out  1  enable pulse to cross drawer
c_x / c_y / c_color / c_writeEn / c_done  in  8/7/3/1/1  tick drawer outputs
w_x / w_y / w_color / w_writeEn / w_done  in  8/7/3/1/1  cross drawer outputs
vga_x  out  8  pixel x to VGA adapter
vga_y  out  7  pixel y to VGA adapter
vga_color  out  3  pixel colour to VGA adapter
vga_plot  out  1  write strobe to VGA adapter

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, including drw_reset_n (drawers held disabled); sel=0; timers cleared.
- sel register: loaded with ~result_correct when result_valid=1 in IDLE (1 = cross). Constant for the whole sequence.
- States and transitions:
  - IDLE: drw_reset_n=0. result_valid -> ARM and clear error. result_valid in any other state is ignored (no queueing).
  - ARM (1 cycle): drw_reset_n=1, drw_clear=0 -> START.
  - START (1 cycle): selected enable=1, the other 0 -> DRAW.
  - DRAW: wait for selected done=1. Done -> HOLD. Timer reaches TIMEOUT_CYCLES-1 -> ABORT. Done and timeout in the same cycle: done wins.
  - HOLD: drw_reset_n=0. Count HOLD_CYCLES cycles -> ERASE_ARM.
  - ERASE_ARM (1 cycle): drw_reset_n=1, drw_clear=1 -> ERASE_START.
  - ERASE_START (1 cycle): selected enable=1, drw_clear=1 -> ERASE.
  - ERASE: drw_clear=1. Done -> FINISH. Timeout -> ABORT.
  - ABORT (1 cycle): set error=1, drw_reset_n=0 -> FINISH.
  - FINISH (1 cycle): finished=1, drw_reset_n=0 -> IDLE.
- drw_reset_n is 1 in ARM, START, DRAW, ERASE_ARM, ERASE_START and ERASE, and 0 everywhere else.
- drw_clear is held 1 from ERASE_ARM through ERASE, so the drawer's colour stays black for the whole erase pass.
- Timer: one 26-bit counter shared by DRAW, HOLD and ERASE. Cleared on every state entry. Saturates; no wrap.
- Pixel mux:
  - Registered, latency 1 cycle: vga_x/y/color take the selected drawer's x/y/color each cycle.
  - vga_plot = selected writeEn AND state in {DRAW, ERASE}, registered on the same edge.
  - In all other states vga_plot=0; vga_x/y/color hold their last value.
  - The unselected drawer's inputs never reach the VGA outputs.
- Reset mid-sequence: immediate return to IDLE. Any partially drawn symbol stays on screen; no erase is attempted.

Test Plan:
- Reset then idle 20 cycles -> busy=0, drw_reset_n=0, vga_plot=0, finished never pulses.
- HOLD_CYCLES=8, TIMEOUT_CYCLES=100. Pulse result_valid with result_correct=1. Model drawer raises c_writeEn for 5 cycles, then c_done on the 6th -> c_enable high exactly 1 cycle (2 cycles after the pulse), w_enable=0, 5 vga_plot cycles each 1 cycle after c_writeEn, HOLD lasts 8 cycles, erase pass has drw_clear=1, one finished pulse, error=0.
- Same setup with result_correct=0 and stimulus on w_* -> w_enable pulses twice, c_* activity (c_writeEn toggling) produces no vga_plot.
- Drawer never asserts done, TIMEOUT_CYCLES=100 -> ABORT after 100 DRAW cycles, error=1, finished pulse, drw_reset_n=0. Next result_valid clears error.
- Extra result_valid pulse during HOLD -> ignored; exactly one finished pulse, sel unchanged.
- reset_n low during DRAW -> asynchronous return to IDLE with all outputs 0 before the next clk edge. A new result afterwards completes normally.
